// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin arbiter sharing one resource among up to NUM_REQ
// requesters. The owner keeps its grant until the resource pulses `done`.
// On release the arbiter picks the next owner in the same cycle, so grants can
// follow each other with no idle cycle in between. All outputs are registered.
//
// Optional feature, macro ARB_TIMEOUT_EN: a watchdog that forces a release
// after TIMEOUT_CYCLES busy cycles with no `done`. The forced release pulses
// `timeout`. If the macro is not defined, `timeout` is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req        in   [NUM_REQ]   request per requester
//   done       in   one-cycle pulse: current owner's transfer complete
//   gnt        out  [NUM_REQ]   one-hot grant, zero when idle
//   gnt_valid  out  high while any grant is active
//   sel        out  [SEL_WIDTH] index of the current or last owner (mux select)
//   timeout    out  one-cycle pulse on forced release (ARB_TIMEOUT_EN only)

module rr_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 16,
    parameter int unsigned SEL_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 gnt_valid,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 timeout
);

    // Reject configurations that cannot work.
    if (NUM_REQ < 2 || NUM_REQ > (1 << SEL_WIDTH)) begin : g_bad_num_req
        $error("rr_bus_arbiter: NUM_REQ must be in 2..2**SEL_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("rr_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e               state;
    logic [SEL_WIDTH-1:0] ptr;       // requester with the highest priority

    logic                 win_found;
    logic [SEL_WIDTH-1:0] win_idx;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [SEL_WIDTH-1:0] next_ptr;
    int                   cand;

    logic                 release_now;  // owner gives up the grant at this edge
    logic                 arb_now;      // an arbitration decision is taken at this edge

    // Rotating priority search: ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = int'(ptr) + i;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = SEL_WIDTH'(cand);
            end
        end
        win_onehot[win_idx] = win_found;
    end

    // After a grant, the winner gets the lowest priority.
    always_comb begin
        if (win_idx == SEL_WIDTH'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win_idx + 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt;
    logic            force_rel;

    // A `done` in the same cycle takes precedence, so no timeout pulse then.
    assign force_rel   = (state == StBusy) && !done && (cnt == CntW'(TIMEOUT_CYCLES - 1));
    assign release_now = (state == StBusy) && (done || force_rel);

    // The count restarts on every new grant. It stays at 0 while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= force_rel;
            if (state == StIdle || release_now) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    assign release_now = (state == StBusy) && done;
    assign timeout     = 1'b0;
`endif

    // While busy, new requests (and the owner dropping its req) are ignored
    // until release. `done` while idle has no effect.
    assign arb_now = (state == StIdle) || release_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            sel       <= '0;
        end else if (arb_now) begin
            if (win_found) begin
                state     <= StBusy;
                gnt       <= win_onehot;
                gnt_valid <= 1'b1;
                sel       <= win_idx;
                ptr       <= next_ptr;
            end else begin
                // `sel` holds the last owner so the mux output stays stable.
                state     <= StIdle;
                gnt       <= '0;
                gnt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
module tb_rr_bus_arbiter;

    localparam int N  = 16;
    localparam int SW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [SW-1:0] sel;
    logic          timeout;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(
        .NUM_REQ       (N),
        .SEL_WIDTH     (SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .sel      (sel),
        .timeout  (timeout)
    );

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic          done;
        logic [N-1:0]  gnt;
        logic          valid;
        logic [SW-1:0] sel;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [N-1:0] e_gnt, input logic e_valid,
                             input logic [SW-1:0] e_sel, input logic e_to);
        check({name, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({name, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
        check({name, ".sel"}, 32'(sel), 32'(e_sel));
        check({name, ".timeout"}, 32'(timeout), 32'(e_to));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] e_gnt;

        rst  = 1'b1;
        req  = '0;
        done = 1'b0;

        //                rst   req       done  gnt       valid sel
        // reset, including reset while done is high
        vecs.push_back('{1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 4'h0});
        vecs.push_back('{1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 4'h0});
        // first grant after reset goes to 0; owner drop is ignored
        vecs.push_back('{1'b0, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 4'h0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 4'h0});
        vecs.push_back('{1'b0, 16'hFFFF, 1'b1, 16'h0002, 1'b1, 4'h1});
        // release to idle; done while idle is ignored
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'h1});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'h1});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h1});
        // move ptr to 14, then 0009 -> 0 then 3
        vecs.push_back('{1'b0, 16'h2000, 1'b0, 16'h2000, 1'b1, 4'hD});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'hD});
        vecs.push_back('{1'b0, 16'h0009, 1'b0, 16'h0001, 1'b1, 4'h0});
        vecs.push_back('{1'b0, 16'h0009, 1'b0, 16'h0001, 1'b1, 4'h0});
        vecs.push_back('{1'b0, 16'h0009, 1'b1, 16'h0008, 1'b1, 4'h3});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'h3});
        // ptr 15, grant 15, ptr wraps to 0
        vecs.push_back('{1'b0, 16'h4000, 1'b0, 16'h4000, 1'b1, 4'hE});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'hE});
        vecs.push_back('{1'b0, 16'h8000, 1'b0, 16'h8000, 1'b1, 4'hF});
        vecs.push_back('{1'b0, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 4'h0});
        // owner 5 drops req; done to idle keeps sel
        vecs.push_back('{1'b0, 16'h0020, 1'b1, 16'h0020, 1'b1, 4'h5});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0020, 1'b1, 4'h5});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'h5});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'h5});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h5});
        // mid-operation reset while busy on 9
        vecs.push_back('{1'b0, 16'h0200, 1'b0, 16'h0200, 1'b1, 4'h9});
        vecs.push_back('{1'b0, 16'h0204, 1'b0, 16'h0200, 1'b1, 4'h9});
        vecs.push_back('{1'b1, 16'h0204, 1'b0, 16'h0000, 1'b0, 4'h0});
        vecs.push_back('{1'b0, 16'h0204, 1'b0, 16'h0004, 1'b1, 4'h2});
        vecs.push_back('{1'b0, 16'h0204, 1'b1, 16'h0200, 1'b1, 4'h9});
        vecs.push_back('{1'b0, 16'h0204, 1'b1, 16'h0004, 1'b1, 4'h2});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'h2});
        // single requester re-granted back-to-back
        vecs.push_back('{1'b0, 16'h0008, 1'b0, 16'h0008, 1'b1, 4'h3});
        vecs.push_back('{1'b0, 16'h0008, 1'b1, 16'h0008, 1'b1, 4'h3});
        vecs.push_back('{1'b0, 16'h0008, 1'b1, 16'h0008, 1'b1, 4'h3});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'h3});

        #2;
        foreach (vecs[i]) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].valid, vecs[i].sel, 1'b0);
        end

        // Round robin with all requesting, done every third cycle: 0,1,...,15,0.
        rst  = 1'b1;
        req  = '1;
        done = 1'b0;
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k <= N; k++) begin
            for (int c = 0; c < 3; c++) begin
                e_gnt          = '0;
                e_gnt[k % N]   = 1'b1;
                check_out($sformatf("rr%0d_%0d", k, c), e_gnt, 1'b1, SW'(k % N), 1'b0);
                done = (c == 2);
                step();
            end
        end
        done = 1'b0;

        // Owner 1 never sees done while 1 and 2 keep requesting.
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        req = 16'h0002;
        step();
        check_out("to_grant", 16'h0002, 1'b1, 4'h1, 1'b0);
        req = 16'h0006;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            step();
            check_out($sformatf("to_hold%0d", i), 16'h0002, 1'b1, 4'h1, 1'b0);
        end
        step();
        check_out("to_fire", 16'h0004, 1'b1, 4'h2, 1'b1);
        step();
        check_out("to_after", 16'h0004, 1'b1, 4'h2, 1'b0);
        for (int i = 2; i < TO; i++) begin
            step();
        end
        // count is at its limit; done wins and no pulse is expected
        done = 1'b1;
        step();
        check_out("to_done_wins", 16'h0002, 1'b1, 4'h1, 1'b0);
        done = 1'b0;
`else
        for (int i = 0; i < 110; i++) begin
            step();
            check_out($sformatf("hold%0d", i), 16'h0002, 1'b1, 4'h1, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
